stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux.sv | 148 ++++++++++++++
 tb/tb_stream_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// stream_mux: N-channel packet-aware stream multiplexer with a single registered output stage.
// Define STREAM_MUX_RR_EN for round-robin arbitration in IDLE; otherwise the lowest valid index wins.
module stream_mux #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int Delay = 50
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_chan,
    input  logic                 out_ready
);
    localparam int CW = $clog2(N);

    // Delay only shapes structural gate models, and this block is pure RTL; supported N is 2..8.
    if (N < 2 || N > 8 || Delay < 0) begin : g_unsupported_config
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     lock_chan_q, lock_chan_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [CW-1:0]     out_chan_q, out_chan_d;
    logic              load_en_s;
    logic              accept_s;
    logic              grant_valid_s;
    logic [CW-1:0]     grant_idx_s;
`ifdef STREAM_MUX_RR_EN
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    // Grant selection: the locked channel owns the output, otherwise arbitrate among valid channels.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        if (state_q == LOCKED) begin
            grant_valid_s = in_valid[lock_chan_q];
            grant_idx_s   = lock_chan_q;
        end else begin
            // Walk from the lowest to the highest priority so the last hit is the winner.
            for (int i = N - 1; i >= 0; i--) begin
`ifdef STREAM_MUX_RR_EN
                grant_idx_s   = in_valid[(int'(rr_ptr_q) + i) % N] ? CW'((int'(rr_ptr_q) + i) % N) : grant_idx_s;
                grant_valid_s = grant_valid_s | in_valid[(int'(rr_ptr_q) + i) % N];
`else
                grant_idx_s   = in_valid[i] ? CW'(i) : grant_idx_s;
                grant_valid_s = grant_valid_s | in_valid[i];
`endif
            end
        end
    end

    // Handshakes, output-stage next values and lock/IDLE transitions.
    always_comb begin
        load_en_s   = !out_valid_q || out_ready;
        accept_s    = grant_valid_s && load_en_s;
        in_ready    = '0;
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
`ifdef STREAM_MUX_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        // in_ready is combinational, so it must be masked while reset is held.
        if (reset_n && load_en_s) begin
            if (state_q == LOCKED) begin
                in_ready[lock_chan_q] = 1'b1;
            end else begin
                in_ready[grant_idx_s] = grant_valid_s;
            end
        end else begin
            in_ready = '0;
        end

        if (load_en_s) begin
            out_valid_d = accept_s;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            out_data_d  = in_data[int'(grant_idx_s) * WIDTH +: WIDTH];
            out_last_d  = in_last[grant_idx_s];
            out_chan_d  = grant_idx_s;
            lock_chan_d = grant_idx_s;
            state_d     = in_last[grant_idx_s] ? IDLE : LOCKED;
        end else begin
            state_d     = state_q;
        end

`ifdef STREAM_MUX_RR_EN
        if (accept_s && in_last[grant_idx_s]) begin
            rr_ptr_d = (grant_idx_s == CW'(N - 1)) ? '0 : grant_idx_s + CW'(1'b1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // State, lock owner and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lock_chan_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Round-robin search start pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (N=4, WIDTH=8); honours STREAM_MUX_RR_EN when defined.
module tb_stream_mux;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk;
    logic           reset_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [CW-1:0]  out_chan;
    logic           out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    stream_mux #(.WIDTH(W), .N(N), .Delay(50)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] d, input logic l);
        in_data[k*W +: W] = d;
        in_last[k]        = l;
    endtask

    task automatic test_reset;
        reset_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'hDEADBEEF;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_cmp++; if (out_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single_beat;
        reset_n = 1'b1;
        in_valid = 4'b0001; set_ch(0, 8'hA5, 1'b1);
        settle();
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL single_in_ready: got %b want 0001", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", out_data); end
        n_cmp++; if (out_chan !== 2'd0) begin n_bad++; $display("FAIL single_chan: got %0d want 0", out_chan); end
        n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b want 1", out_last); end
        in_valid = 4'b0000;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_locked;
        in_valid = 4'b0100; set_ch(2, 8'h11, 1'b0); set_ch(1, 8'h77, 1'b1);
        settle();
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_rdy0: got %b want 0100", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h11 || out_chan !== 2'd2 || out_last !== 1'b0)
            begin n_bad++; $display("FAIL lock_beat0: got %h/%0d/%b want 11/2/0", out_data, out_chan, out_last); end
        in_valid = 4'b0010;
        settle();
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_gap_rdy: got %b want 0100", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lock_gap_valid: got %b want 0", out_valid); end
        in_valid = 4'b0110; set_ch(2, 8'h22, 1'b0);
        settle();
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_rdy1: got %b want 0100", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_chan !== 2'd2)
            begin n_bad++; $display("FAIL lock_beat1: got %b/%h/%0d want 1/22/2", out_valid, out_data, out_chan); end
        set_ch(2, 8'h33, 1'b1);
        settle();
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_rdy2: got %b want 0100", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h33 || out_chan !== 2'd2 || out_last !== 1'b1)
            begin n_bad++; $display("FAIL lock_beat2: got %h/%0d/%b want 33/2/1", out_data, out_chan, out_last); end
        in_valid = 4'b0010;
        settle();
        n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_release_rdy: got %b want 0010", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h77 || out_chan !== 2'd1)
            begin n_bad++; $display("FAIL lock_release_beat: got %h/%0d want 77/1", out_data, out_chan); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_arbitration;
        int exp_ch[5];
`ifdef STREAM_MUX_RR_EN
        exp_ch = '{0, 1, 2, 3, 0};
`else
        exp_ch = '{0, 0, 0, 0, 0};
`endif
        reset_n = 1'b0; #2; reset_n = 1'b1;
        for (int k = 0; k < N; k++) set_ch(k, 8'(8'hC0 + k), 1'b1);
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_cmp++; if (in_ready !== (4'b0001 << exp_ch[i]))
                begin n_bad++; $display("FAIL arb_rdy%0d: got %b want %b", i, in_ready, 4'b0001 << exp_ch[i]); end
            tick();
            n_cmp++; if (out_chan !== 2'(exp_ch[i]) || out_data !== 8'(8'hC0 + exp_ch[i]))
                begin n_bad++; $display("FAIL arb_beat%0d: got chan %0d data %h want chan %0d", i, out_chan, out_data, exp_ch[i]); end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure;
        in_valid = 4'b0001; set_ch(0, 8'h5A, 1'b1);
        tick();
        n_cmp++; if (out_data !== 8'h5A || out_valid !== 1'b1)
            begin n_bad++; $display("FAIL bp_load: got %b/%h want 1/5a", out_valid, out_data); end
        out_ready = 1'b0; set_ch(0, 8'h99, 1'b1);
        for (int i = 0; i < 5; i++) begin
            settle();
            n_cmp++; if (in_ready !== 4'b0000 || out_data !== 8'h5A || out_valid !== 1'b1)
                begin n_bad++; $display("FAIL bp_hold%0d: got rdy %b data %h valid %b want 0000/5a/1", i, in_ready, out_data, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        settle();
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_resume_rdy: got %b want 0001", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h99) begin n_bad++; $display("FAIL bp_resume0: got %h want 99", out_data); end
        set_ch(0, 8'h9A, 1'b1);
        tick();
        n_cmp++; if (out_data !== 8'h9A || out_valid !== 1'b1)
            begin n_bad++; $display("FAIL bp_resume1: got %b/%h want 1/9a", out_valid, out_data); end
        in_valid = 4'b0000;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_packet;
        in_valid = 4'b1000; set_ch(3, 8'h31, 1'b0);
        tick();
        set_ch(3, 8'h32, 1'b0);
        tick();
        n_cmp++; if (out_data !== 8'h32 || out_chan !== 2'd3)
            begin n_bad++; $display("FAIL mid_beat1: got %h/%0d want 32/3", out_data, out_chan); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000)
            begin n_bad++; $display("FAIL mid_async: got valid %b data %h rdy %b want 0/00/0000", out_valid, out_data, in_ready); end
        set_ch(0, 8'h0C, 1'b1); set_ch(3, 8'h33, 1'b0); in_valid = 4'b1001;
        #2;
        reset_n = 1'b1;
        settle();
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_rdy: got %b want 0001", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h0C || out_chan !== 2'd0 || out_last !== 1'b1)
            begin n_bad++; $display("FAIL mid_regrant: got %b/%h/%0d/%b want 1/0c/0/1", out_valid, out_data, out_chan, out_last); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back;
        in_valid = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            set_ch(1, 8'(8'h40 + i), (i == 7));
            settle();
            n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL b2b_rdy%0d: got %b want 0010", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(8'h40 + i) || out_chan !== 2'd1)
                begin n_bad++; $display("FAIL b2b_beat%0d: got %b/%h/%0d want 1/%h/1", i, out_valid, out_data, out_chan, 8'(8'h40 + i)); end
        end
        in_valid = 4'b0000;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_locked();
        test_arbitration();
        test_backpressure();
        test_reset_mid_packet();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
